// File: rtl/dyadic_boolean_accumulator.sv
// Folds each input frame bit-wise through a 4-entry truth table latched on its first word.
// Define DYADIC_BOOLEAN_ACCUMULATOR_COUNT_EN to include the saturating frame word counter.
module dyadic_boolean_accumulator #(
    parameter int WORD_WIDTH  = 8,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [3:0]             truth_table,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WORD_WIDTH-1:0]  in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_WIDTH-1:0]  out_data,
    output logic [COUNT_WIDTH-1:0] out_count
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        OUTPUT
    } state_t;

    state_t                state;
    logic                  run;
    logic [WORD_WIDTH-1:0] acc;
    logic [3:0]            op;
    logic                  accept;

    function automatic logic [WORD_WIDTH-1:0] apply_op(
        input logic [3:0]            tt,
        input logic [WORD_WIDTH-1:0] a,
        input logic [WORD_WIDTH-1:0] b
    );
        logic [WORD_WIDTH-1:0] r;
        for (int i = 0; i < WORD_WIDTH; i++) begin
            r[i] = tt[{a[i], b[i]}];
        end
        return r;
    endfunction

    // Asserts with reset_n, releases on a clock edge so every flop below leaves reset together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    assign in_ready = run && (state != OUTPUT);
    assign accept   = in_valid && in_ready;
    assign out_data = acc;

    always_ff @(posedge clock or negedge run) begin
        if (!run) begin
            state     <= IDLE;
            acc       <= '0;
            op        <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc <= in_data;
                        op  <= truth_table;
                        if (in_last) begin
                            state     <= OUTPUT;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc <= apply_op(op, acc, in_data);
                        if (in_last) begin
                            state     <= OUTPUT;
                            out_valid <= 1'b1;
                        end
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef DYADIC_BOOLEAN_ACCUMULATOR_COUNT_EN
    logic [COUNT_WIDTH-1:0] count;

    // Restarts at one on a frame's first word and sticks at all-ones.
    always_ff @(posedge clock or negedge run) begin
        if (!run) begin
            count <= '0;
        end else if (accept) begin
            if (state == IDLE) begin
                count <= COUNT_WIDTH'(1);
            end else if (count != '1) begin
                count <= count + COUNT_WIDTH'(1);
            end
        end
    end

    assign out_count = count;
`else
    assign out_count = '0;
`endif

endmodule
